// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-side memory request bridge.
// Size encodings match the FUNCT3_* load/store values used by the core.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bridge_state_t;

  // Start of the MMIO register window where natural alignment is enforced
  localparam logic [31:0] MMIO_ALIGN_BASE_DEFAULT = 32'h0080_0008;
  // Watchdog limit in clk cycles (meaningful only with MEM_TIMEOUT_EN)
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT  = 4096;

  // funct3[1:0] access size encodings
  localparam logic [1:0] FUNCT3_SIZE_B = 2'b00;
  localparam logic [1:0] FUNCT3_SIZE_H = 2'b01;
  localparam logic [1:0] FUNCT3_SIZE_W = 2'b10;

  // True when an access inside the MMIO window is not naturally aligned
  function automatic logic is_misaligned(input logic [31:0] addr,
                                         input logic [2:0]  funct3,
                                         input logic [31:0] base);
    logic bad;
    bad = 1'b0;
    if (addr >= base) begin
      case (funct3[1:0])
        FUNCT3_SIZE_B: bad = 1'b0;
        FUNCT3_SIZE_H: bad = addr[0];
        FUNCT3_SIZE_W: bad = (addr[1:0] != 2'b00);
        default:       bad = 1'b0;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_req_bridge.sv
// mem_req_bridge: converts one valid/ready load/store into the memory block's
// active-low chip-enable protocol and returns rdata plus a fault flag.
// Optional watchdog enabled by defining MEM_TIMEOUT_EN; without it WAIT
// waits indefinitely and rsp_timeout is tied low.
import mem_bridge_pkg::*;

module mem_req_bridge #(
  parameter logic [31:0] MMIO_ALIGN_BASE = MMIO_ALIGN_BASE_DEFAULT
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        rsp_timeout,
  output logic        mem_ce,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_memwrite,
  input  logic [31:0] mem_dataout,
  input  logic        mem_busy,
  input  logic        mem_valid,
  input  logic        mem_fault
);

  bridge_state_t r_state;
  logic          r_req_ready;
  logic          r_mem_ce;
  logic          r_seen_busy;
  logic [2:0]    r_mem_funct3;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_datain;
  logic          r_mem_memwrite;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_fault;
  logic          r_rsp_timeout;
  logic          w_misaligned;
  logic          w_unused;

  // Completion is taken from busy/fault; read-valid is informational only
  assign w_unused     = mem_valid;
  assign w_misaligned = is_misaligned(req_addr, req_funct3, MMIO_ALIGN_BASE);

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wdog;
  logic        w_wdog_expired;
  assign w_wdog_expired = (r_wdog == WDOG_LAST);
`endif

  // Request FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_req_ready    <= 1'b1;
      r_mem_ce       <= 1'b1;
      r_seen_busy    <= 1'b0;
      r_mem_funct3   <= 3'd0;
      r_mem_addr     <= 32'd0;
      r_mem_datain   <= 32'd0;
      r_mem_memwrite <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= 32'd0;
      r_rsp_fault    <= 1'b0;
      r_rsp_timeout  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_wdog         <= 16'd0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_mem_funct3   <= req_funct3;
            r_mem_addr     <= req_addr;
            r_mem_datain   <= req_wdata;
            r_mem_memwrite <= req_we;
            r_req_ready    <= 1'b0;
            if (w_misaligned) begin
              // Reject without ever touching the memory
              r_state       <= ST_RESP;
              r_rsp_valid   <= 1'b1;
              r_rsp_fault   <= 1'b1;
              r_rsp_timeout <= 1'b0;
              r_rsp_rdata   <= 32'd0;
            end else begin
              r_state  <= ST_ISSUE;
              r_mem_ce <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          // Memory samples its inputs this cycle
          r_state     <= ST_WAIT;
          r_seen_busy <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          r_wdog      <= 16'd0;
`endif
        end
        ST_WAIT: begin
          if (mem_busy) r_seen_busy <= 1'b1;
`ifdef MEM_TIMEOUT_EN
          r_wdog <= r_wdog + 16'd1;
`endif
          if (mem_fault) begin
            r_state       <= ST_RESP;
            r_mem_ce      <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_fault   <= 1'b1;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= 32'd0;
          end else if (r_seen_busy && !mem_busy) begin
            r_state       <= ST_RESP;
            r_mem_ce      <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_fault   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= r_mem_memwrite ? 32'd0 : mem_dataout;
          end
`ifdef MEM_TIMEOUT_EN
          else if (w_wdog_expired) begin
            // Abort a hung peripheral transfer
            r_state       <= ST_RESP;
            r_mem_ce      <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_fault   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= 32'd0;
          end
`endif
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_mem_ce    <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign mem_ce       = r_mem_ce;
  assign mem_funct3   = r_mem_funct3;
  assign mem_addr     = r_mem_addr;
  assign mem_datain   = r_mem_datain;
  assign mem_memwrite = r_mem_memwrite;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_fault    = r_rsp_fault;
  assign rsp_timeout  = r_rsp_timeout;

endmodule
